free_list_nway: RTL and testbench

FREE_LIST_NWAY -- requirements
Module: free_list_nway

---
 rtl/sys_defs.sv | 9 +
 rtl/popcount_compact.sv | 21 ++
 rtl/free_list_nway.sv | 126 ++++++++++++
 tb/tb_free_list_nway.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared machine-wide defaults: register file sizes, rename width and the physical tag type.
package sys_defs;
  localparam int PHYS_REGS_DEF = 64;
  localparam int ARCH_REGS_DEF = 32;
  localparam int WAYS_DEF      = 2;
  localparam int TAGW_DEF      = $clog2(PHYS_REGS_DEF);

  typedef logic [TAGW_DEF-1:0] tag_t;
endpackage

// File: rtl/popcount_compact.sv
// Free-way compaction: offset of each valid way among the valid ways below it, plus total count.
module popcount_compact #(
  parameter int WAYS = 2
) (
  input  logic [WAYS-1:0]                  valid_i,
  output logic [WAYS*$clog2(WAYS+1)-1:0]   offsets_o,
  output logic [$clog2(WAYS+1)-1:0]        count_o
);
  localparam int CW = $clog2(WAYS+1);

  always_comb begin
    logic [CW-1:0] run;
    run       = '0;
    offsets_o = '0;
    for (int k = 0; k < WAYS; k++) begin
      offsets_o[k*CW +: CW] = run;
      run = run + CW'(valid_i[k]);
    end
    count_o = run;
  end
endmodule

// File: rtl/free_list_nway.sv
// N-way physical register free list (circular buffer) with optional head checkpointing.
// Checkpointing is built only when FREE_LIST_CKPT_EN is defined.
module free_list_nway
  import sys_defs::*;
#(
  parameter int PHYS_REGS = PHYS_REGS_DEF,
  parameter int ARCH_REGS = ARCH_REGS_DEF,
  parameter int WAYS      = WAYS_DEF
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [$clog2(WAYS+1)-1:0]            alloc_cnt,
  output logic                                 alloc_grant,
  output logic [WAYS*$clog2(PHYS_REGS)-1:0]    alloc_tags,
  input  logic [WAYS-1:0]                      free_valid,
  input  logic [WAYS*$clog2(PHYS_REGS)-1:0]    free_tags,
  input  logic                                 ckpt_save,
  input  logic                                 ckpt_restore,
  output logic [$clog2(PHYS_REGS-ARCH_REGS+1)-1:0] free_count,
  output logic                                 overflow_err
);
  localparam int DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int TAGW  = $clog2(PHYS_REGS);
  localparam int CNTW  = $clog2(DEPTH+1);
  localparam int ACW   = $clog2(WAYS+1);
  localparam int PTRW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW    = CNTW + 1;
  localparam int SW1   = SW + 1;

  logic [TAGW-1:0]     buf_q [DEPTH];
  logic [PTRW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNTW-1:0]     count_q, count_d;
  logic                ovf_q;
  logic [WAYS*ACW-1:0] offsets;
  logic [ACW-1:0]      pop_cnt;
  logic [SW-1:0]       granted, room, accepted;
  logic [WAYS-1:0]     accept;
  logic                restore_hold;

  // Pointer add modulo DEPTH; n never exceeds DEPTH so one subtraction suffices.
  function automatic logic [PTRW-1:0] ptr_add(input logic [PTRW-1:0] p, input logic [SW-1:0] n);
    logic [SW1-1:0] s;
    s = SW1'(p) + SW1'(n);
    if (s >= SW1'(DEPTH)) s = s - SW1'(DEPTH);
    return PTRW'(s);
  endfunction

  popcount_compact #(.WAYS(WAYS)) u_compact (
    .valid_i  (free_valid),
    .offsets_o(offsets),
    .count_o  (pop_cnt)
  );

`ifdef FREE_LIST_CKPT_EN
  logic [PTRW-1:0] snap_q;
  logic            snap_vld_q;
  logic [PTRW-1:0] snap_diff;
  assign restore_hold = ckpt_restore;
`else
  logic unused_ckpt;
  assign restore_hold = 1'b0;
  assign unused_ckpt  = ckpt_save | ckpt_restore;
`endif

  // Allocation handshake: alloc_cnt is the request, alloc_grant answers in the same cycle,
  // and the tags on alloc_tags are consumed at the clock edge only when granted.
  always_comb begin
    alloc_grant = (alloc_cnt != '0) && (SW'(alloc_cnt) <= SW'(count_q)) && !restore_hold;
    granted     = alloc_grant ? SW'(alloc_cnt) : '0;
    room        = SW'(DEPTH) - SW'(count_q) + granted;
    for (int k = 0; k < WAYS; k++)
      accept[k] = free_valid[k] && (SW'(offsets[k*ACW +: ACW]) < room);
    accepted    = (SW'(pop_cnt) > room) ? room : SW'(pop_cnt);
    head_d      = ptr_add(head_q, granted);
    tail_d      = ptr_add(tail_q, accepted);
    count_d     = CNTW'(SW'(count_q) - granted + accepted);
`ifdef FREE_LIST_CKPT_EN
    snap_diff   = ptr_add(tail_d, SW'(DEPTH) - SW'(snap_q));
    if (ckpt_restore && snap_vld_q) begin
      head_d  = snap_q;
      // Equal pointers are ambiguous: full unless nothing is left between head and tail.
      if (snap_diff == '0 && (SW'(count_q) + accepted) != '0) count_d = CNTW'(DEPTH);
      else                                                  count_d = CNTW'(snap_diff);
    end
`endif
  end

  always_comb begin
    alloc_tags = '0;
    for (int k = 0; k < WAYS; k++)
      alloc_tags[k*TAGW +: TAGW] = buf_q[ptr_add(head_q, SW'(k))];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= TAGW'(ARCH_REGS + i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CNTW'(DEPTH);
      ovf_q   <= 1'b0;
    end else begin
      for (int k = 0; k < WAYS; k++)
        if (accept[k])
          buf_q[ptr_add(tail_q, SW'(offsets[k*ACW +: ACW]))] <= free_tags[k*TAGW +: TAGW];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_q | (SW'(pop_cnt) > room);
    end
  end

`ifdef FREE_LIST_CKPT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
    end else if (ckpt_save && !ckpt_restore) begin
      snap_q     <= head_d;
      snap_vld_q <= 1'b1;
    end
  end
`endif

  assign free_count   = count_q;
  assign overflow_err = ovf_q;
endmodule

// File: tb/tb_free_list_nway.sv
// Directed bench for free_list_nway with a FIFO model of the free tags.
module tb_free_list_nway;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  alloc_cnt;
  logic        alloc_grant;
  logic [11:0] alloc_tags;
  logic [1:0]  free_valid;
  logic [11:0] free_tags;
  logic        ckpt_save, ckpt_restore;
  logic [5:0]  free_count;
  logic        overflow_err;

  int errors = 0;
  int checks = 0;
  logic [5:0] exp_q[$];

  free_list_nway dut (
    .clk(clk), .reset(reset), .alloc_cnt(alloc_cnt), .alloc_grant(alloc_grant),
    .alloc_tags(alloc_tags), .free_valid(free_valid), .free_tags(free_tags),
    .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore), .free_count(free_count),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] ac, input logic [1:0] fv, input logic [5:0] t0,
                       input logic [5:0] t1, input logic sv, input logic rs);
    alloc_cnt = ac; free_valid = fv; free_tags = {t1, t0};
    ckpt_save = sv; ckpt_restore = rs;
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(6'(32 + i));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL reset_count: got %0d want 32", free_count); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", overflow_err); end
    checks++; if (alloc_grant !== 1'b0) begin errors++; $display("FAIL reset_grant_idle: got %0b want 0", alloc_grant); end
    checks++; if (alloc_tags[5:0] !== 6'd32) begin errors++; $display("FAIL reset_tag0: got %0d want 32", alloc_tags[5:0]); end
    checks++; if (alloc_tags[11:6] !== 6'd33) begin errors++; $display("FAIL reset_tag1: got %0d want 33", alloc_tags[11:6]); end
  endtask

  task automatic test_alloc_basic();
    drive(2, 0, 0, 0, 0, 0);
    checks++; if (alloc_grant !== 1'b1) begin errors++; $display("FAIL alloc1_grant: got %0b want 1", alloc_grant); end
    checks++; if (alloc_tags !== {6'd33, 6'd32}) begin errors++; $display("FAIL alloc1_tags: got %0d,%0d want 32,33", alloc_tags[5:0], alloc_tags[11:6]); end
    tick(); void'(exp_q.pop_front()); void'(exp_q.pop_front());
    checks++; if (free_count !== 6'd30) begin errors++; $display("FAIL alloc1_count: got %0d want 30", free_count); end
    checks++; if (alloc_tags !== {6'd35, 6'd34}) begin errors++; $display("FAIL alloc2_tags: got %0d,%0d want 34,35", alloc_tags[5:0], alloc_tags[11:6]); end
    tick(); void'(exp_q.pop_front()); void'(exp_q.pop_front());
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (free_count !== 6'd28) begin errors++; $display("FAIL alloc2_count: got %0d want 28", free_count); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 13; i++) begin
      drive(2, 0, 0, 0, 0, 0);
      checks++; if (alloc_grant !== 1'b1 || alloc_tags[5:0] !== exp_q[0]) begin errors++; $display("FAIL drain_step%0d: grant %0b tag %0d want 1 tag %0d", i, alloc_grant, alloc_tags[5:0], exp_q[0]); end
      tick(); void'(exp_q.pop_front()); void'(exp_q.pop_front());
    end
    drive(1, 0, 0, 0, 0, 0);
    tick(); void'(exp_q.pop_front());
    drive(2, 0, 0, 0, 0, 0);
    checks++; if (free_count !== 6'd1) begin errors++; $display("FAIL drain_count1: got %0d want 1", free_count); end
    checks++; if (alloc_grant !== 1'b0) begin errors++; $display("FAIL drain_over_grant: got %0b want 0", alloc_grant); end
    tick();
    drive(1, 0, 0, 0, 0, 0);
    checks++; if (free_count !== 6'd1) begin errors++; $display("FAIL drain_denied_count: got %0d want 1", free_count); end
    checks++; if (alloc_tags[5:0] !== 6'd63) begin errors++; $display("FAIL drain_head_held: got %0d want 63", alloc_tags[5:0]); end
    checks++; if (alloc_grant !== 1'b1) begin errors++; $display("FAIL drain_last_grant: got %0b want 1", alloc_grant); end
    tick(); void'(exp_q.pop_front());
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (free_count !== 6'd0) begin errors++; $display("FAIL drain_empty: got %0d want 0", free_count); end
  endtask

  task automatic test_same_cycle_free();
    drive(1, 2'b01, 6'd40, 0, 0, 0);
    checks++; if (alloc_grant !== 1'b0) begin errors++; $display("FAIL bypass_grant: got %0b want 0", alloc_grant); end
    tick(); exp_q.push_back(6'd40);
    drive(1, 0, 0, 0, 0, 0);
    checks++; if (free_count !== 6'd1) begin errors++; $display("FAIL bypass_count: got %0d want 1", free_count); end
    checks++; if (alloc_grant !== 1'b1 || alloc_tags[5:0] !== 6'd40) begin errors++; $display("FAIL bypass_next: grant %0b tag %0d want 1 tag 40", alloc_grant, alloc_tags[5:0]); end
    tick(); void'(exp_q.pop_front());
  endtask

  task automatic test_refill();
    for (int i = 0; i < 16; i++) begin
      drive(0, 2'b11, 6'(32 + 2*i), 6'(33 + 2*i), 0, 0);
      tick(); exp_q.push_back(6'(32 + 2*i)); exp_q.push_back(6'(33 + 2*i));
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL refill_count: got %0d want 32", free_count); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL refill_ovf: got %0b want 0", overflow_err); end
  endtask

  task automatic test_wrap();
    logic [5:0] prev, got;
    prev = '0;
    for (int i = 0; i < 40; i++) begin
      drive(1, (i > 0) ? 2'b01 : 2'b00, prev, 0, 0, 0);
      checks++; if (alloc_grant !== 1'b1 || alloc_tags[5:0] !== exp_q[0]) begin errors++; $display("FAIL wrap_tag%0d: grant %0b tag %0d want 1 tag %0d", i, alloc_grant, alloc_tags[5:0], exp_q[0]); end
      tick();
      got = exp_q.pop_front();
      if (i > 0) exp_q.push_back(prev);
      prev = got;
      checks++; if (free_count !== 6'd31) begin errors++; $display("FAIL wrap_count%0d: got %0d want 31", i, free_count); end
    end
    drive(0, 2'b01, prev, 0, 0, 0);
    tick(); exp_q.push_back(prev);
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (free_count !== 6'd32 || overflow_err !== 1'b0) begin errors++; $display("FAIL wrap_end: count %0d ovf %0b want 32 0", free_count, overflow_err); end
  endtask

  task automatic test_full_alloc_free();
    logic [5:0] t;
    t = exp_q[0];
    drive(1, 2'b01, t, 0, 0, 0);
    checks++; if (alloc_grant !== 1'b1) begin errors++; $display("FAIL fullswap_grant: got %0b want 1", alloc_grant); end
    tick(); void'(exp_q.pop_front()); exp_q.push_back(t);
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (free_count !== 6'd32 || overflow_err !== 1'b0) begin errors++; $display("FAIL fullswap_state: count %0d ovf %0b want 32 0", free_count, overflow_err); end
  endtask

  task automatic test_overflow();
    logic [5:0] x;
    x = exp_q[0];
    drive(1, 0, 0, 0, 0, 0);
    tick(); void'(exp_q.pop_front());
    drive(0, 2'b11, x, 6'd7, 0, 0);
    tick(); exp_q.push_back(x);
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL partial_count: got %0d want 32", free_count); end
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL partial_ovf: got %0b want 1", overflow_err); end
    drive(0, 2'b11, 6'd8, 6'd9, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
    checks++; if (free_count !== 6'd32 || overflow_err !== 1'b1) begin errors++; $display("FAIL full_drop: count %0d ovf %0b want 32 1", free_count, overflow_err); end
    for (int i = 0; i < 16; i++) begin
      drive(2, 0, 0, 0, 0, 0);
      checks++; if (alloc_tags !== {exp_q[1], exp_q[0]}) begin errors++; $display("FAIL ovf_drain%0d: got %0d,%0d want %0d,%0d", i, alloc_tags[5:0], alloc_tags[11:6], exp_q[0], exp_q[1]); end
      tick(); void'(exp_q.pop_front()); void'(exp_q.pop_front());
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (free_count !== 6'd0 || overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: count %0d ovf %0b want 0 1", free_count, overflow_err); end
  endtask

  task automatic test_reset_inflight();
    reset = 1'b1;
    drive(2, 2'b11, 6'd5, 6'd6, 1, 1);
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    checks++; if (free_count !== 6'd32 || overflow_err !== 1'b0) begin errors++; $display("FAIL rst_inflight_state: count %0d ovf %0b want 32 0", free_count, overflow_err); end
    checks++; if (alloc_tags !== {6'd33, 6'd32}) begin errors++; $display("FAIL rst_inflight_tags: got %0d,%0d want 32,33", alloc_tags[5:0], alloc_tags[11:6]); end
  endtask

`ifdef FREE_LIST_CKPT_EN
  task automatic test_ckpt();
    drive(2, 0, 0, 0, 0, 0); tick();
    drive(2, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0); tick();
    for (int i = 0; i < 3; i++) begin drive(2, 0, 0, 0, 0, 0); tick(); end
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (free_count !== 6'd22) begin errors++; $display("FAIL ckpt_pre_count: got %0d want 22", free_count); end
    drive(0, 2'b11, 6'd32, 6'd33, 0, 0); tick();
    drive(2, 0, 0, 0, 0, 1);
    checks++; if (alloc_grant !== 1'b0) begin errors++; $display("FAIL ckpt_restore_grant: got %0b want 0", alloc_grant); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (free_count !== 6'd30) begin errors++; $display("FAIL ckpt_count: got %0d want 30", free_count); end
    checks++; if (alloc_tags !== {6'd37, 6'd36}) begin errors++; $display("FAIL ckpt_head: got %0d,%0d want 36,37", alloc_tags[5:0], alloc_tags[11:6]); end
  endtask
`else
  task automatic test_ckpt_ignored();
    drive(2, 0, 0, 0, 1, 1);
    checks++; if (alloc_grant !== 1'b1) begin errors++; $display("FAIL ckpt_off_grant: got %0b want 1", alloc_grant); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (free_count !== 6'd30 || alloc_tags[5:0] !== 6'd34) begin errors++; $display("FAIL ckpt_off_state: count %0d tag %0d want 30 34", free_count, alloc_tags[5:0]); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    alloc_cnt = '0; free_valid = '0; free_tags = '0; ckpt_save = 1'b0; ckpt_restore = 1'b0;
    @(negedge clk);
    test_reset();
    test_alloc_basic();
    test_drain();
    test_same_cycle_free();
    test_refill();
    test_wrap();
    test_full_alloc_free();
    test_overflow();
    test_reset_inflight();
`ifdef FREE_LIST_CKPT_EN
    test_ckpt();
`else
    test_ckpt_ignored();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
